// File: rtl/reg_dump_ctrl_if.sv
// reg_dump_ctrl_if: groups the dump controller's pipeline, regfile and debug-transmitter signals.
interface reg_dump_ctrl_if #(
    parameter int B = 32,
    parameter int W = 5
);
    logic         dump_start;
    logic         pipe_halted;
    logic [W-1:0] id_read_reg_1;
    logic [W-1:0] id_read_reg_2;
    logic [B-1:0] read_data_1;
    logic         tx_ready;
    logic [W-1:0] read_reg_1;
    logic [W-1:0] read_reg_2;
    logic         halt_req;
    logic         dump_valid;
    logic [B-1:0] dump_data;
    logic [W-1:0] dump_addr;
    logic         dump_busy;
    logic         dump_done;

    modport master (
        output dump_start, pipe_halted, id_read_reg_1, id_read_reg_2, read_data_1, tx_ready,
        input  read_reg_1, read_reg_2, halt_req, dump_valid, dump_data, dump_addr, dump_busy, dump_done
    );

    modport slave (
        input  dump_start, pipe_halted, id_read_reg_1, id_read_reg_2, read_data_1, tx_ready,
        output read_reg_1, read_reg_2, halt_req, dump_valid, dump_data, dump_addr, dump_busy, dump_done
    );
endinterface

// File: rtl/reg_dump_ctrl.sv
// reg_dump_ctrl: halts the pipeline, steals regfile read port 1 and streams every register
// in ascending order to the debug transmitter over valid/ready.
module reg_dump_ctrl #(
    parameter int B = 32,
    parameter int W = 5
) (
    input logic            clk,
    input logic            rst,
    reg_dump_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, HALT_WAIT, ADDR, CAPTURE, SEND, DONE} state_t;

    state_t       state, state_n;
    logic [W-1:0] idx, idx_n;
    logic         halt_n, valid_n, done_n;
    logic [B-1:0] data_n;
    logic [W-1:0] addr_n;

    assign bus.read_reg_1 = (state == ADDR || state == CAPTURE) ? idx : bus.id_read_reg_1;
    assign bus.read_reg_2 = bus.id_read_reg_2;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        halt_n  = bus.halt_req;
        valid_n = bus.dump_valid;
        data_n  = bus.dump_data;
        addr_n  = bus.dump_addr;
        done_n  = 1'b0;
        case (state)
            IDLE: if (bus.dump_start) begin
                state_n = HALT_WAIT;
                idx_n   = '0;
                halt_n  = 1'b1;
            end
            HALT_WAIT: if (bus.pipe_halted) state_n = ADDR;
            ADDR: state_n = bus.pipe_halted ? CAPTURE : HALT_WAIT;
            // a halt drop here aborts the capture so the same idx is re-read on resume
            CAPTURE: if (!bus.pipe_halted) state_n = HALT_WAIT;
            else begin
                state_n = SEND;
                data_n  = bus.read_data_1;
                addr_n  = idx;
                valid_n = 1'b1;
            end
            SEND: if (bus.tx_ready) begin
                valid_n = 1'b0;
                state_n = &idx ? DONE : ADDR;
                idx_n   = &idx ? idx : idx + W'(1);
            end
            DONE: begin
                done_n  = 1'b1;
                halt_n  = 1'b0;
                idx_n   = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            idx            <= '0;
            bus.halt_req   <= 1'b0;
            bus.dump_valid <= 1'b0;
            bus.dump_data  <= '0;
            bus.dump_addr  <= '0;
            bus.dump_busy  <= 1'b0;
            bus.dump_done  <= 1'b0;
        end else begin
            state          <= state_n;
            idx            <= idx_n;
            bus.halt_req   <= halt_n;
            bus.dump_valid <= valid_n;
            bus.dump_data  <= data_n;
            bus.dump_addr  <= addr_n;
            bus.dump_busy  <= state_n != IDLE;
            bus.dump_done  <= done_n;
        end
    end
endmodule

// File: doc/reg_dump_ctrl.md
Name: reg_dump_ctrl

Overview:
Sequences a full dump of the 2**W-entry register file to the debug unit. On request it stalls the pipeline and takes over register-file read port 1. It then reads every register in ascending address order, and hands each word to the debug transmitter over a valid/ready handshake. Outside a dump, both read-port addresses pass straight through from the ID stage.

Parameters:
B, 32, data width of a register word
W, 5, register address width; the dump covers addresses 0 .. 2**W-1

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous reset, active-high
i_dump_start  in  1  one-cycle request to begin a dump
i_pipe_halted  in  1  pipeline is stalled and write-back is drained (no regfile writes while high)
i_id_read_reg_1  in  W  ID-stage read address 1
i_id_read_reg_2  in  W  ID-stage read address 2
i_read_data_1  in  B  register-file read data 1 (regfile updates it on negedge)
i_tx_ready  in  1  debug transmitter can accept a word
o_read_reg_1  out  W  address to regfile read port 1
o_read_reg_2  out  W  address to regfile read port 2 (always i_id_read_reg_2)
o_halt_req  out  1  request pipeline stall
o_dump_valid  out  1  o_dump_data/o_dump_addr hold a word
o_dump_data  out  B  register word being sent
o_dump_addr  out  W  register index of o_dump_data
o_dump_busy  out  1  dump in progress (any state except IDLE)
o_dump_done  out  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset (async, i_reset=1): state=IDLE, idx=0.
- Reset values: o_halt_req=0, o_dump_valid=0, o_dump_data=0, o_dump_addr=0, o_dump_busy=0, o_dump_done=0.
- All outputs are registered except the read-address mux.
- States: IDLE, HALT_WAIT, ADDR, CAPTURE, SEND, DONE.
- IDLE: on i_dump_start=1 -> HALT_WAIT, idx<=0, o_halt_req<=1.
- HALT_WAIT: on i_pipe_halted=1 -> ADDR. o_halt_req stays 1.
- ADDR: o_read_reg_1=idx. Next cycle -> CAPTURE. The regfile samples the address on the intervening negedge.
- CAPTURE: o_read_reg_1=idx still held. At the closing posedge:
  - o_dump_data<=i_read_data_1, o_dump_addr<=idx, o_dump_valid<=1
  - -> SEND
- SEND: o_dump_valid=1, with data and addr held stable until o_dump_valid&i_tx_ready at a posedge. On that handshake:
  - o_dump_valid<=0
  - if idx==2**W-1 -> DONE; else idx<=idx+1 -> ADDR
- DONE: o_dump_done=1 for exactly one cycle, o_halt_req<=0, -> IDLE.
- Read-address mux (combinational):
  - In ADDR and CAPTURE, o_read_reg_1=idx.
  - In all other states, o_read_reg_1=i_id_read_reg_1.
  - o_read_reg_2 is always i_id_read_reg_2.
- Per-word minimum: 3 cycles (ADDR, CAPTURE, SEND with ready high).
- Minimum full dump: 2 + 3*2**W cycles from the i_dump_start edge to the o_dump_done pulse, with i_pipe_halted already high and i_tx_ready stuck at 1. Default W=5 gives 98.
- Boundary conditions:
  - i_dump_start while o_dump_busy=1: ignored, no restart.
  - i_pipe_halted falls in ADDR or CAPTURE: -> HALT_WAIT, idx kept, o_halt_req stays 1. Resume re-reads the same idx; no word is skipped or duplicated.
  - i_pipe_halted falls in SEND: ignored. The latched word is still delivered; the drop is checked on the following ADDR.
  - i_tx_ready low indefinitely: remain in SEND with outputs stable. No timeout.
  - i_reset mid-dump: immediate return to IDLE, o_halt_req=0, o_dump_valid=0, no o_dump_done pulse.
  - idx wraps only via DONE. idx is W bits wide; 2**W-1 is detected before the increment.

Test Plan:
- Reset and pass-through: preload reg k = 32'hA000_0000+k. With i_dump_start=0, drive i_id_read_reg_1=7 -> o_read_reg_1=7, o_halt_req=0, o_dump_busy=0. Assert i_reset -> all outputs 0.
- Full dump: i_pipe_halted=1, i_tx_ready=1, pulse i_dump_start -> 32 handshakes in order, addr 0..31, data 32'hA000_0000..32'hA000_001F. o_dump_done pulses once, 98 cycles after the start edge. o_halt_req returns to 0 the same cycle.
- Backpressure: i_tx_ready low for 5 cycles on word 3 -> o_dump_valid, o_dump_addr=3, o_dump_data=32'hA000_0003 stable all 5 cycles. Then exactly one transfer of word 3.
- Halt wait and drop: i_pipe_halted=0 at start for 4 cycles -> state stays HALT_WAIT, o_halt_req=1, no valid. Later, drop i_pipe_halted during CAPTURE of idx 10 for 2 cycles -> word 10 sent once, no gap or duplicate.
- Start while busy: second i_dump_start at word 15 -> ignored; single o_dump_done, 32 words total.
- Reset mid-dump: i_reset during SEND of word 20 -> o_dump_valid=0, o_halt_req=0, no done pulse. A new start then dumps from addr 0.
